// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one ack-handshaked memory bus between data and fetch.
// Define MEM_ARB_TIMEOUT_EN to add a TIMEOUT_CYCLES bus watchdog on bus_err.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        i_ce,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_stallreq,
  input  logic        d_ce,
  input  logic        d_we,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_stallreq,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE, BUS_D, BUS_I, DONE_D, DONE_I, DRAIN
  } state_t;

  state_t      r_state, w_state_n;
  logic        r_cyc, w_cyc_n;
  logic        r_stb, w_stb_n;
  logic        r_we, w_we_n;
  logic [3:0]  r_sel, w_sel_n;
  logic [31:0] r_addr, w_addr_n;
  logic [31:0] r_wdata, w_wdata_n;
  logic [31:0] r_irdata, w_irdata_n;
  logic [31:0] r_drdata, w_drdata_n;
  logic        r_err, w_err_n;
  logic        w_tmo;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0]  r_cnt;

  // Abort on the cycle the no-ack counter would reach the limit.
  assign w_tmo = !bus_ack && (r_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Watchdog counter restarts whenever the state changes.
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (w_state_n != r_state)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 8'd1;
  end
`else
  assign w_tmo = 1'b0;
`endif

  // State and bus/result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_irdata <= '0;
      r_drdata <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cyc    <= w_cyc_n;
      r_stb    <= w_stb_n;
      r_we     <= w_we_n;
      r_sel    <= w_sel_n;
      r_addr   <= w_addr_n;
      r_wdata  <= w_wdata_n;
      r_irdata <= w_irdata_n;
      r_drdata <= w_drdata_n;
      r_err    <= w_err_n;
    end
  end

  // Next-state and bus sequencing; data has fixed priority over fetch.
  always_comb begin
    w_state_n  = r_state;
    w_cyc_n    = r_cyc;
    w_stb_n    = r_stb;
    w_we_n     = r_we;
    w_sel_n    = r_sel;
    w_addr_n   = r_addr;
    w_wdata_n  = r_wdata;
    w_irdata_n = r_irdata;
    w_drdata_n = r_drdata;
    w_err_n    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!flush) begin
          if (d_ce) begin
            w_state_n = BUS_D;
            w_cyc_n   = 1'b1;
            w_stb_n   = 1'b1;
            w_we_n    = d_we;
            w_sel_n   = d_sel;
            w_addr_n  = d_addr;
            w_wdata_n = d_wdata;
          end else if (i_ce) begin
            w_state_n = BUS_I;
            w_cyc_n   = 1'b1;
            w_stb_n   = 1'b1;
            w_we_n    = 1'b0;
            w_sel_n   = 4'b1111;
            w_addr_n  = i_addr;
          end
        end
      end
      BUS_D, BUS_I: begin
        if (bus_ack || w_tmo) begin
          w_cyc_n = 1'b0;
          w_stb_n = 1'b0;
          w_we_n  = 1'b0;
          w_sel_n = '0;
          if (bus_ack && flush) begin
            w_state_n = IDLE;
          end else begin
            w_err_n = w_tmo;
            if (r_state == BUS_D) begin
              w_state_n = DONE_D;
              if (!r_we)
                w_drdata_n = w_tmo ? '0 : bus_rdata;
            end else begin
              w_state_n  = DONE_I;
              w_irdata_n = w_tmo ? '0 : bus_rdata;
            end
          end
        end else if (flush) begin
          w_state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (bus_ack || w_tmo) begin
          w_state_n = IDLE;
          w_cyc_n   = 1'b0;
          w_stb_n   = 1'b0;
          w_we_n    = 1'b0;
          w_sel_n   = '0;
          w_err_n   = w_tmo;
        end
      end
      DONE_D, DONE_I: begin
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  assign d_stallreq = d_ce & (r_state != DONE_D);
  assign i_stallreq = i_ce & (r_state != DONE_I);

  assign bus_cyc   = r_cyc;
  assign bus_stb   = r_stb;
  assign bus_we    = r_we;
  assign bus_sel   = r_sel;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign d_rdata   = r_drdata;
  assign i_rdata   = r_irdata;
  assign bus_err   = r_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: table-driven single accesses plus hand sequences for
// priority, flush/drain, reset and (with MEM_ARB_TIMEOUT_EN) timeout.
module tb_mem_bus_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        i_ce, d_ce, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_sel;
  logic [31:0] i_rdata, d_rdata;
  logic        i_stallreq, d_stallreq;
  logic        bus_cyc, bus_stb, bus_we, bus_ack, bus_err;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_ce(i_ce), .i_addr(i_addr), .i_rdata(i_rdata),
    .i_stallreq(i_stallreq),
    .d_ce(d_ce), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_stallreq(d_stallreq),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we),
    .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_at;
    logic [31:0] bus_rd;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NV = 6;
  vec_t tbl [NV];
  vec_t sb [$];

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, e;
    int   cycles, err_seen, rel_at;
    bit   done;
    logic stall;

    tbl[0] = '{1, 0, 4'hF, 32'h100, 32'h0,        3, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[1] = '{1, 1, 4'hF, 32'h200, 32'hCAFEF00D, 1, 32'h11111111, 32'hDEADBEEF};
    tbl[2] = '{0, 0, 4'hF, 32'h400, 32'h0,        1, 32'h00000013, 32'h00000013};
    tbl[3] = '{0, 0, 4'hF, 32'h404, 32'h0,        4, 32'h12345678, 32'h12345678};
    tbl[4] = '{1, 0, 4'h4, 32'h008, 32'h77777777, 2, 32'h00AB0000, 32'h00AB0000};
    tbl[5] = '{1, 1, 4'h8, 32'h00C, 32'h99000000, 5, 32'h22222222, 32'h00AB0000};

    rst = 1; flush = 0; i_ce = 0; d_ce = 0; d_we = 0; d_sel = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; bus_ack = 0; bus_rdata = 0;
    @(negedge clk);
    step();
    chk("rst bus_cyc", bus_cyc, 0);
    chk("rst bus_stb", bus_stb, 0);
    chk("rst bus_we", bus_we, 0);
    chk("rst bus_sel", bus_sel, 0);
    chk("rst bus_addr", bus_addr, 0);
    chk("rst bus_wdata", bus_wdata, 0);
    chk("rst i_rdata", i_rdata, 0);
    chk("rst d_rdata", d_rdata, 0);
    chk("rst bus_err", bus_err, 0);
    rst = 0;
    step();

    for (int k = 0; k < NV; k++) begin
      v = tbl[k];
      d_ce = v.is_d; d_we = v.we; d_sel = v.sel;
      d_addr = v.addr; d_wdata = v.wdata;
      i_ce = !v.is_d; i_addr = v.addr;
      sb.push_back(v);
      cycles = 0; done = 0;
      for (int n = 1; n <= 20 && !done; n++) begin
        step();
        if (bus_cyc) cycles++;
        if (n == 1) begin
          chk($sformatf("v%0d bus_we", k), bus_we, v.is_d ? v.we : 1'b0);
          chk($sformatf("v%0d bus_sel", k), bus_sel, v.is_d ? v.sel : 4'hF);
          chk($sformatf("v%0d bus_addr", k), bus_addr, v.addr);
          if (v.is_d)
            chk($sformatf("v%0d bus_wdata", k), bus_wdata, v.wdata);
        end
        stall = v.is_d ? d_stallreq : i_stallreq;
        if (!stall) begin
          done = 1;
          e = sb.pop_front();
          chk($sformatf("v%0d latency", k), n, e.ack_at + 1);
          chk($sformatf("v%0d cyc_cycles", k), cycles, e.ack_at);
          chk($sformatf("v%0d bus_stb", k), bus_stb, 0);
          chk($sformatf("v%0d bus_err", k), bus_err, 0);
          if (e.is_d)
            chk($sformatf("v%0d d_rdata", k), d_rdata, e.exp_rd);
          else
            chk($sformatf("v%0d i_rdata", k), i_rdata, e.exp_rd);
          d_ce = 0; i_ce = 0; bus_ack = 0;
        end else begin
          bus_ack = (n == v.ack_at);
          bus_rdata = bus_ack ? v.bus_rd : $urandom;
        end
      end
      chk($sformatf("v%0d completed", k), done, 1);
      bus_ack = 0; d_ce = 0; i_ce = 0;
      step();
    end

    // Both ports request together: store goes first, fetch follows.
    d_ce = 1; d_we = 1; d_sel = 4'b0011; d_addr = 32'h300;
    d_wdata = 32'h12345678; i_ce = 1; i_addr = 32'h500;
    step();
    chk("pri d bus_cyc", bus_cyc, 1);
    chk("pri d bus_we", bus_we, 1);
    chk("pri d bus_sel", bus_sel, 4'b0011);
    chk("pri d bus_addr", bus_addr, 32'h300);
    chk("pri d bus_wdata", bus_wdata, 32'h12345678);
    chk("pri i_stall c1", i_stallreq, 1);
    bus_ack = 1;
    step();
    bus_ack = 0;
    chk("pri done_d d_stall", d_stallreq, 0);
    chk("pri done_d i_stall", i_stallreq, 1);
    chk("pri done_d bus_cyc", bus_cyc, 0);
    d_ce = 0;
    step();
    chk("pri idle bus_cyc", bus_cyc, 0);
    chk("pri idle i_stall", i_stallreq, 1);
    step();
    chk("pri i bus_cyc", bus_cyc, 1);
    chk("pri i bus_we", bus_we, 0);
    chk("pri i bus_sel", bus_sel, 4'hF);
    chk("pri i bus_addr", bus_addr, 32'h500);
    chk("pri i i_stall", i_stallreq, 1);
    bus_ack = 1; bus_rdata = 32'h0BADF00D;
    step();
    bus_ack = 0;
    chk("pri done_i i_stall", i_stallreq, 0);
    chk("pri i_rdata", i_rdata, 32'h0BADF00D);
    chk("pri d_rdata kept", d_rdata, 32'h00AB0000);
    i_ce = 0;
    step();

    // Flush during a fetch: drain the bus, discard the data.
    i_ce = 1; i_addr = 32'h600;
    step();
    chk("fl c1 bus_cyc", bus_cyc, 1);
    step();
    flush = 1;
    step();
    flush = 0;
    chk("fl c3 bus_cyc", bus_cyc, 1);
    chk("fl c3 bus_addr", bus_addr, 32'h600);
    chk("fl c3 i_stall", i_stallreq, 1);
    step();
    chk("fl c4 bus_cyc", bus_cyc, 1);
    chk("fl c4 i_stall", i_stallreq, 1);
    bus_ack = 1; bus_rdata = 32'hAAAA5555;
    step();
    bus_ack = 0;
    chk("fl c5 bus_cyc", bus_cyc, 0);
    chk("fl c5 i_rdata", i_rdata, 32'h0BADF00D);
    chk("fl c5 no done_i", i_stallreq, 1);
    i_ce = 0;
    step();
    chk("fl c6 bus_cyc", bus_cyc, 0);

    // Reset in the middle of a load; the late ack must be ignored.
    d_ce = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h700;
    step();
    chk("rm c1 bus_cyc", bus_cyc, 1);
    rst = 1;
    step();
    rst = 0; d_ce = 0;
    chk("rm bus_cyc", bus_cyc, 0);
    chk("rm bus_stb", bus_stb, 0);
    chk("rm d_rdata", d_rdata, 0);
    chk("rm i_rdata", i_rdata, 0);
    chk("rm bus_addr", bus_addr, 0);
    bus_ack = 1; bus_rdata = 32'h55AA55AA;
    step();
    bus_ack = 0;
    chk("rm late d_rdata", d_rdata, 0);
    chk("rm late bus_cyc", bus_cyc, 0);
    step();

`ifdef MEM_ARB_TIMEOUT_EN
    // Load with no ack: watchdog aborts after TMO bus cycles.
    d_ce = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h800;
    d_wdata = 0; bus_rdata = 32'hFFFFFFFF;
    cycles = 0; err_seen = 0; rel_at = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (bus_cyc) cycles++;
      if (bus_err) err_seen++;
      if (rel_at == 0 && !d_stallreq && d_ce) begin
        rel_at = n;
        chk("to d_rdata", d_rdata, 0);
        chk("to bus_err", bus_err, 1);
        d_ce = 0;
      end
    end
    chk("to cyc_cycles", cycles, TMO);
    chk("to release", rel_at, TMO + 1);
    chk("to err pulses", err_seen, 1);
`else
    // Without the watchdog a missing ack just keeps the stall up.
    d_ce = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h800;
    err_seen = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (bus_err) err_seen++;
    end
    chk("noto bus_cyc", bus_cyc, 1);
    chk("noto d_stall", d_stallreq, 1);
    chk("noto bus_err", err_seen, 0);
    bus_ack = 1; bus_rdata = 32'h31415926;
    step();
    bus_ack = 0;
    chk("noto d_rdata", d_rdata, 32'h31415926);
    d_ce = 0;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
